// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
//   arb_state_e : arbiter FSM state encoding
//   mst_idx_t   : master index (0 = m0, 1 = m1)
//   ADDR_W/DATA_W : shared memory port widths
//   idx_onehot  : master index -> one-hot grant vector
package mem_arb_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_e;

   typedef logic mst_idx_t;

   function automatic logic [1:0] idx_onehot(input mst_idx_t idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/arb_pick2.sv
// Combinational winner selection between two masters.
// Ports:
//   req         : raw level requests {m1, m0}
//   mask        : masters whose request is ignored this cycle (just served)
//   last_served : round-robin pointer, the master served most recently
//   own_active  : a bus lock is in force; only owner may win
//   owner       : lock owner index
//   yield_prio  : a forced lock release is pending; m0 priority blocking is
//                 suspended so the other master can be granted
//   valid/win   : a winner exists / its index
// Parameter PRIO_M0: 0 = round-robin ties, 1 = m0 wins ties and blocks m1
// whenever m0_req is high.
module arb_pick2
   import mem_arb_pkg::*;
#(
   parameter int PRIO_M0 = 0
) (
   input  logic [1:0] req,
   input  logic [1:0] mask,
   input  mst_idx_t   last_served,
   input  logic       own_active,
   input  mst_idx_t   owner,
   input  logic       yield_prio,
   output logic       valid,
   output mst_idx_t   win
);

   logic [1:0] elig;

   always_comb begin
      elig = req & ~mask;
      if (own_active) begin
         elig = elig & idx_onehot(owner);
      end else if ((PRIO_M0 != 0) && req[0] && !yield_prio) begin
         // m0 blocks m1 even while m0 itself is masked after being served
         elig[1] = 1'b0;
      end
      valid = |elig;
      win   = 1'b0;
      if (elig == 2'b11) begin
         win = (PRIO_M0 != 0) ? 1'b0 : ~last_served;
      end else if (elig[1]) begin
         win = 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port memory. Each access takes one
// ACCESS cycle on the shared port followed by one DONE cycle carrying the ack.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mX_req/we/addr/wdata       : master requests (level, held until ack)
//   mX_ack, mX_rdata           : one-cycle completion pulse, held read data
//   mX_lock                    : bus-lock request (only with MEM_ARB_LOCK_EN)
//   writeM, addressM, outM     : shared memory port
//   inM                        : memory read data for addressM
//   grant, busy                : one-hot owner in ACCESS/DONE, FSM not idle
// Build option: define MEM_ARB_LOCK_EN to add lock ports and lock ownership
// with a forced release after MAX_LOCK consecutive locked accesses.
//
// state     | meaning
// ST_IDLE   | no transaction; arbitrate among all requests
// ST_ACCESS | command on memory port for one cycle; reads capture inM
// ST_DONE   | ack to winner; arbitrate the other master for back-to-back
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int PRIO_M0  = 0,
   parameter int MAX_LOCK = 4
) (
   input  logic              clk,
   input  logic              reset,
`ifdef MEM_ARB_LOCK_EN
   input  logic              m0_lock,
   input  logic              m1_lock,
`endif
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              writeM,
   output logic [ADDR_W-1:0] addressM,
   output logic [DATA_W-1:0] outM,
   input  logic [DATA_W-1:0] inM,
   output logic [1:0]        grant,
   output logic              busy
);

   if (MAX_LOCK < 1) begin : g_bad_max_lock
      $error("MAX_LOCK must be at least 1");
   end

   arb_state_e        state_q, state_d;
   mst_idx_t          cmd_idx_q, cmd_idx_d;
   mst_idx_t          last_q, last_d;
   logic              cmd_we_q, cmd_we_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;

   logic [1:0] req_v;
   logic [1:0] mask;
   logic       arb_point;
   logic       pick_valid;
   mst_idx_t   pick_win;
   logic       own_active;
   mst_idx_t   owner;
   logic       yield_prio;

   assign req_v     = {m1_req, m0_req};
   assign arb_point = (state_q == ST_IDLE) || (state_q == ST_DONE);
   // The master being acked may not immediately win again.
   assign mask      = (state_q == ST_DONE) ? idx_onehot(cmd_idx_q) : 2'b00;

`ifdef MEM_ARB_LOCK_EN
   localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

   logic             owned_q, owned_d;
   mst_idx_t         owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             yield_q, yield_d;
   logic [1:0]       lock_v;

   assign lock_v     = {m1_lock, m0_lock};
   assign owner      = owner_q;
   assign own_active = owned_q && lock_v[owner_q];
   assign yield_prio = yield_q;

   always_comb begin
      owned_d = owned_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      yield_d = yield_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            yield_d = 1'b0;
            if (owned_q && !lock_v[owner_q]) begin
               owned_d = 1'b0;
               cnt_d   = '0;
            end
         end
         ST_ACCESS: begin
            if (lock_v[cmd_idx_q]) begin
               if (cnt_q == CNT_W'(MAX_LOCK - 1)) begin
                  // Limit reached: drop ownership and let the other master in.
                  owned_d = 1'b0;
                  cnt_d   = '0;
                  yield_d = 1'b1;
               end else begin
                  owned_d = 1'b1;
                  owner_d = cmd_idx_q;
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end else begin
               owned_d = 1'b0;
               cnt_d   = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owned_q <= 1'b0;
         owner_q <= 1'b0;
         cnt_q   <= '0;
         yield_q <= 1'b0;
      end else begin
         owned_q <= owned_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         yield_q <= yield_d;
      end
   end
`else
   assign own_active = 1'b0;
   assign owner      = 1'b0;
   assign yield_prio = 1'b0;
`endif

   arb_pick2 #(
      .PRIO_M0(PRIO_M0)
   ) u_pick (
      .req        (req_v),
      .mask       (mask),
      .last_served(last_q),
      .own_active (own_active),
      .owner      (owner),
      .yield_prio (yield_prio),
      .valid      (pick_valid),
      .win        (pick_win)
   );

   always_comb begin
      state_d     = state_q;
      cmd_idx_d   = cmd_idx_q;
      last_d      = last_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      case (state_q)
         ST_IDLE:   state_d = ST_IDLE;
         ST_ACCESS: begin
            state_d = ST_DONE;
            if (!cmd_we_q) begin
               if (cmd_idx_q) rdata1_d = inM;
               else           rdata0_d = inM;
            end
         end
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      if (arb_point && pick_valid) begin
         state_d     = ST_ACCESS;
         cmd_idx_d   = pick_win;
         last_d      = pick_win;
         cmd_we_d    = pick_win ? m1_we    : m0_we;
         cmd_addr_d  = pick_win ? m1_addr  : m0_addr;
         cmd_wdata_d = pick_win ? m1_wdata : m0_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cmd_idx_q   <= 1'b0;
         last_q      <= 1'b1;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         cmd_idx_q   <= cmd_idx_d;
         last_q      <= last_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   // Outputs are forced quiet while reset is high so that an ACCESS cut short
   // by reset never presents a write to memory on the reset edge.
   assign writeM   = !reset && (state_q == ST_ACCESS) && cmd_we_q;
   assign addressM = reset ? '0 : cmd_addr_q;
   assign outM     = reset ? '0 : cmd_wdata_q;
   assign m0_ack   = !reset && (state_q == ST_DONE) && !cmd_idx_q;
   assign m1_ack   = !reset && (state_q == ST_DONE) && cmd_idx_q;
   assign m0_rdata = reset ? '0 : rdata0_q;
   assign m1_rdata = reset ? '0 : rdata1_q;
   assign busy     = !reset && (state_q != ST_IDLE);
   assign grant    = (!reset && ((state_q == ST_ACCESS) || (state_q == ST_DONE)))
                     ? idx_onehot(cmd_idx_q) : 2'b00;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter PRIO_M0, default 0: 0 selects round-robin arbitration; 1 gives fixed priority to master 0.
REQ-002 Parameter MAX_LOCK, default 4: maximum consecutive locked accesses before forced release (used only with MEM_ARB_LOCK_EN).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m0_req, m1_req  in  1 each  level request; held high until the matching ack.
REQ-006 m0_we, m1_we  in  1 each  1 = write, 0 = read; stable while req is high.
REQ-007 m0_addr, m1_addr  in  16 each  word address into the memory map.
REQ-008 m0_wdata, m1_wdata  in  16 each  write data.
REQ-009 m0_ack, m1_ack  out  1 each  single-cycle completion pulse.
REQ-010 m0_rdata, m1_rdata  out  16 each  read data; valid when ack is high, held until that master's next ack.
REQ-011 m0_lock, m1_lock  in  1 each  bus-lock request; present only with MEM_ARB_LOCK_EN.
REQ-012 writeM  out  1, addressM  out  16, outM  out  16: shared memory port, driven to the memory block.
REQ-013 inM  in  16: memory read data, combinationally valid in the same cycle as addressM.
REQ-014 grant  out  2: one-hot owner during ACCESS/DONE, else 0; busy  out  1: high when state is not IDLE.

Function
REQ-015 FSM states: IDLE, ACCESS, DONE.
REQ-016 IDLE: if any eligible req is high, latch the winner's index, we, addr and wdata into command registers and enter ACCESS next cycle; otherwise stay in IDLE.
REQ-017 ACCESS lasts exactly one cycle: addressM = cmd_addr, outM = cmd_wdata, writeM = cmd_we; on read, inM is captured into the winner's rdata register at the closing edge.
REQ-018 writeM is high only in ACCESS with cmd_we = 1, so each write produces exactly one write cycle.
REQ-019 Outside ACCESS, writeM = 0 and addressM/outM hold the last command values.
REQ-020 DONE: the winner's ack is high for exactly one cycle, and the served master's req is ignored during this cycle.
REQ-021 DONE with the other master's req high: latch that command and go directly to ACCESS; otherwise go to IDLE.
REQ-022 Latency: req high at edge E0 in IDLE -> ACCESS in the cycle after E0 -> ack in the following cycle; back-to-back throughput is one access per 2 cycles.
REQ-023 Round-robin (PRIO_M0 = 0): on simultaneous requests, grant the master not served last; the last-served pointer resets to master 1, so master 0 wins first.
REQ-024 PRIO_M0 = 1: master 0 wins every tie; master 1 is served only when m0_req is low in the arbitration cycle.
REQ-025 A req deasserted before its ack, or addr/we changed mid-transaction, does not affect the latched command, and the ack is still issued.

Reset
REQ-026 Reset has priority over all inputs: state = IDLE, the last-served pointer = master 1, and the lock counter = 0.
REQ-027 Outputs during and after reset: ack = 0, grant = 0, busy = 0, writeM = 0, and addressM, outM and both rdata = 0.
REQ-028 Reset asserted in ACCESS aborts the transaction: no write occurs on that edge and no ack is issued.

Configuration
REQ-029 Macro MEM_ARB_LOCK_EN defined: m0_lock/m1_lock ports exist, and the lock rules below apply.
REQ-030 Lock behaviour: if the winner's lock is high in ACCESS, the arbiter stays owned by that master, and only its req is eligible after DONE.
REQ-031 Lock release: ownership ends when lock is low at an arbitration point, or after MAX_LOCK consecutive locked accesses; a forced release grants the other master next if it is requesting.
REQ-032 Macro MEM_ARB_LOCK_EN undefined: the lock ports and the lock counter are absent, and behaviour is pure REQ-015..025.

Structure
REQ-033 Shared package mem_arb_pkg holds the state enum, ADDR_W = 16, DATA_W = 16 and the master-index type.
REQ-034 Winner selection, covering tie-break, pointer and lock eligibility, is one combinational sub-module, arb_pick2; the FSM, command and rdata registers stay in mem_arbiter.

Verification
REQ-035 Case 1: m0 writes addr 0x0010, data 0xBEEF, then reads 0x0010 -> exactly one writeM cycle, m0_ack 2 cycles after req, m0_rdata = 0xBEEF.
REQ-036 Case 2: m0 and m1 request in the same cycle (read 0x0001 / read 0x0002), PRIO_M0 = 0 -> order m0, m1, m0, m1 over 4 repeats, with acks 2 cycles apart.
REQ-037 Case 3: PRIO_M0 = 1 with m0 requesting continuously -> m1 is never granted until m0_req drops, then m1 is acked 2 cycles later.
REQ-038 Case 4: reset asserted during an ACCESS write of 0x1234 to 0x0005 -> writeM = 0 on that edge, no ack, subsequent read of 0x0005 returns its old value.
REQ-039 Case 5 (MEM_ARB_LOCK_EN, MAX_LOCK = 4): m1 locked with m0 requesting -> exactly 4 m1 accesses, then an m0 grant.
REQ-040 Case 6: m1 changes addr from 0x0100 to 0x0200 while in ACCESS -> addressM stays 0x0100 through DONE.
